// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory arbiter slice.
// Access-size encodings, requester port IDs, default widths and the
// lock-owner encoding used by the arbitration core.
package dmem_pkg;

    localparam int unsigned DEF_AW       = 32;
    localparam int unsigned DEF_DW       = 32;
    localparam int unsigned DEF_MAX_LOCK = 8;

    localparam logic [0:1] DSIZE_BYTE = 2'd0;
    localparam logic [0:1] DSIZE_HALF = 2'd1;
    localparam logic [0:1] DSIZE_WORD = 2'd2;

    localparam logic P_CPU = 1'b0;
    localparam logic P_DBG = 1'b1;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_CPU  = 2'd1,
        OWN_DBG  = 2'd2
    } owner_e;

endpackage

// File: rtl/rr_arb2.sv
// Two-input round-robin arbiter with a bounded lock owner.
// Ports:
//   clk, reset        : clock, synchronous active-high reset
//   req0/req1         : requests
//   lock0/lock1       : keep ownership after this grant
//   gnt0/gnt1         : combinational one-hot (or zero) grant
// State: last granted port, current lock owner, consecutive locked grants.
module rr_arb2
    import dmem_pkg::*;
#(
    parameter int unsigned MAX_LOCK = DEF_MAX_LOCK
) (
    input  logic clk,
    input  logic reset,
    input  logic req0,
    input  logic req1,
    input  logic lock0,
    input  logic lock1,
    output logic gnt0,
    output logic gnt1
);

    localparam int unsigned CW  = $clog2(MAX_LOCK + 1);
    localparam int unsigned CW1 = CW + 1;
    localparam logic [CW-1:0] MAX_C = CW'(MAX_LOCK);
    localparam logic [CW:0]   MAX_W = CW1'(MAX_LOCK);

    logic          last, last_nxt;
    owner_e        owner, owner_nxt;
    logic [CW-1:0] lock_cnt, cnt_nxt, cnt_base;
    logic [CW:0]   cnt_inc;
    logic          own_ok, lock_g;

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            last     <= P_DBG;
            owner    <= OWN_NONE;
            lock_cnt <= '0;
        end else begin
            last     <= last_nxt;
            owner    <= owner_nxt;
            lock_cnt <= cnt_nxt;
        end
    end

    // Grant selection and next-state
    always_comb begin
        gnt0      = 1'b0;
        gnt1      = 1'b0;
        last_nxt  = last;
        owner_nxt = OWN_NONE;
        cnt_nxt   = '0;
        cnt_base  = '0;
        cnt_inc   = '0;
        lock_g    = 1'b0;
        own_ok    = (lock_cnt < MAX_C);

        if (!reset) begin
            if (owner == OWN_CPU && req0 && own_ok) begin
                gnt0 = 1'b1;
            end else if (owner == OWN_DBG && req1 && own_ok) begin
                gnt1 = 1'b1;
            end else if (req0 && !req1) begin
                gnt0 = 1'b1;
            end else if (req1 && !req0) begin
                gnt1 = 1'b1;
            end else if (req0 && req1) begin
                if (last == P_CPU) gnt1 = 1'b1;
                else               gnt0 = 1'b1;
            end
        end

        // Any grant without a fresh lock (or reaching the bound) releases ownership;
        // a lock count restarts when ownership moves to the other port.
        if (gnt0 || gnt1) begin
            last_nxt = gnt1 ? P_DBG : P_CPU;
            lock_g   = gnt1 ? lock1 : lock0;
            cnt_base = (owner == (gnt1 ? OWN_DBG : OWN_CPU)) ? lock_cnt : '0;
            cnt_inc  = {1'b0, cnt_base} + CW1'(1);
            if (lock_g && (cnt_inc < MAX_W)) begin
                owner_nxt = gnt1 ? OWN_DBG : OWN_CPU;
                cnt_nxt   = cnt_inc[CW-1:0];
            end
        end
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Shares one data-memory port between the CPU (port 0) and a loader/debug
// master (port 1): round-robin grants with bounded lock, registered read return.
// Ports:
//   clk, reset                       : clock, synchronous active-high reset
//   reqN/weN/addrN/wdataN/dsizeN/lockN : requester N transaction
//   gntN                             : combinational grant
//   rvalidN/rdataN                   : registered read response (latency 1)
//   mem_addr/mem_wData/mem_writeEnable/mem_dsize/mem_rData : dmem port
// Optional: DMEM_ARB_STATS_EN adds gnt_cnt0, gnt_cnt1, conflict_cnt counters.
module dmem_arbiter
    import dmem_pkg::*;
#(
    parameter int unsigned AW       = DEF_AW,
    parameter int unsigned DW       = DEF_DW,
    parameter int unsigned MAX_LOCK = DEF_MAX_LOCK
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          req0,
    input  logic          req1,
    input  logic          we0,
    input  logic          we1,
    input  logic [0:AW-1] addr0,
    input  logic [0:AW-1] addr1,
    input  logic [0:DW-1] wdata0,
    input  logic [0:DW-1] wdata1,
    input  logic [0:1]    dsize0,
    input  logic [0:1]    dsize1,
    input  logic          lock0,
    input  logic          lock1,
    output logic          gnt0,
    output logic          gnt1,
    output logic          rvalid0,
    output logic          rvalid1,
    output logic [0:DW-1] rdata0,
    output logic [0:DW-1] rdata1,
    output logic [0:AW-1] mem_addr,
    output logic [0:DW-1] mem_wData,
    output logic          mem_writeEnable,
    output logic [0:1]    mem_dsize,
    input  logic [0:DW-1] mem_rData
`ifdef DMEM_ARB_STATS_EN
    ,
    output logic [0:31]   gnt_cnt0,
    output logic [0:31]   gnt_cnt1,
    output logic [0:31]   conflict_cnt
`endif
);

    rr_arb2 #(
        .MAX_LOCK (MAX_LOCK)
    ) u_arb (
        .clk   (clk),
        .reset (reset),
        .req0  (req0),
        .req1  (req1),
        .lock0 (lock0),
        .lock1 (lock1),
        .gnt0  (gnt0),
        .gnt1  (gnt1)
    );

    // Memory mux: port 0 drives the bus whenever port 1 is not granted
    always_comb begin
        if (gnt1) begin
            mem_addr  = addr1;
            mem_wData = wdata1;
            mem_dsize = dsize1;
        end else begin
            mem_addr  = addr0;
            mem_wData = wdata0;
            mem_dsize = dsize0;
        end
        mem_writeEnable = (gnt0 & we0) | (gnt1 & we1);
    end

    // Read response registers
    always_ff @(posedge clk) begin
        if (reset) begin
            rvalid0 <= 1'b0;
            rvalid1 <= 1'b0;
            rdata0  <= '0;
            rdata1  <= '0;
        end else begin
            rvalid0 <= gnt0 & ~we0;
            rvalid1 <= gnt1 & ~we1;
            if (gnt0 && !we0) rdata0 <= mem_rData;
            if (gnt1 && !we1) rdata1 <= mem_rData;
        end
    end

`ifdef DMEM_ARB_STATS_EN
    // Grant and contention counters, wrapping
    always_ff @(posedge clk) begin
        if (reset) begin
            gnt_cnt0     <= '0;
            gnt_cnt1     <= '0;
            conflict_cnt <= '0;
        end else begin
            if (gnt0)         gnt_cnt0     <= gnt_cnt0 + 32'd1;
            if (gnt1)         gnt_cnt1     <= gnt_cnt1 + 32'd1;
            if (req0 && req1) conflict_cnt <= conflict_cnt + 32'd1;
        end
    end
`endif

endmodule
